// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: PC, one 9-bit instruction fetch per cycle, field split, immediate capture.
// Latency: fetch-to-decode 1 cycle; imem_addr and imm_index are combinational from PC / fetched word.
// Backpressure: stall holds PC and the decode register; a taken branch overrides stall and flushes.
//
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   start                 - pulse: begin fetching at address 0 (from IDLE or HALT)
//   imem_addr/imem_instr  - instruction memory address (= PC) and same-cycle read data
//   imm_index/imm_data    - immediate LUT index (= instr[2:0]) and same-cycle result
//   stall                 - downstream hazard, freeze PC and decode register
//   branch_taken/target   - redirect from execute
//   dec_*                 - decode pipeline register towards execute
//   halted                - fetch stopped on the halt encoding
module fetch_decode_stage #(
  parameter int          PC_W       = 10,
  parameter logic [8:0]  HALT_INSTR = 9'h1FF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_instr,
  output logic [2:0]      imm_index,
  input  logic [7:0]      imm_data,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            dec_valid,
  output logic [2:0]      dec_opcode,
  output logic [2:0]      dec_rd,
  output logic [2:0]      dec_rs,
  output logic [7:0]      dec_imm,
  output logic [PC_W-1:0] dec_pc,
  output logic            halted
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]      state_q,      state_d;
  logic [PC_W-1:0] pc_q,         pc_d;
  logic            dec_valid_q,  dec_valid_d;
  logic [2:0]      dec_opcode_q, dec_opcode_d;
  logic [2:0]      dec_rd_q,     dec_rd_d;
  logic [2:0]      dec_rs_q,     dec_rs_d;
  logic [7:0]      dec_imm_q,    dec_imm_d;
  logic [PC_W-1:0] dec_pc_q,     dec_pc_d;
  logic            halted_q,     halted_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    dec_valid_d  = dec_valid_q;
    dec_opcode_d = dec_opcode_q;
    dec_rd_d     = dec_rd_q;
    dec_rs_d     = dec_rs_q;
    dec_imm_d    = dec_imm_q;
    dec_pc_d     = dec_pc_q;
    halted_d     = halted_q;

    case (state_q)
      ST_IDLE: begin
        pc_d        = '0;
        dec_valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (branch_taken) begin
          // Redirect wins over stall; the instruction fetched this cycle is
          // on the wrong path, so it is dropped rather than checked for halt.
          pc_d        = branch_target;
          dec_valid_d = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (imem_instr == HALT_INSTR) begin
          // Halt word is never issued; PC stays pointing at it.
          dec_valid_d = 1'b0;
          state_d     = ST_HALT;
          halted_d    = 1'b1;
        end else begin
          dec_opcode_d = imem_instr[8:6];
          dec_rd_d     = imem_instr[5:3];
          dec_rs_d     = imem_instr[2:0];
          dec_imm_d    = imm_data;
          dec_pc_d     = pc_q;
          dec_valid_d  = 1'b1;
          pc_d         = pc_q + PC_W'(1);
        end
      end
      ST_HALT: begin
        dec_valid_d = 1'b0;
        if (start) begin
          state_d  = ST_RUN;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        pc_d        = '0;
        dec_valid_d = 1'b0;
        halted_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      dec_valid_q  <= 1'b0;
      dec_opcode_q <= '0;
      dec_rd_q     <= '0;
      dec_rs_q     <= '0;
      dec_imm_q    <= '0;
      dec_pc_q     <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dec_valid_q  <= dec_valid_d;
      dec_opcode_q <= dec_opcode_d;
      dec_rd_q     <= dec_rd_d;
      dec_rs_q     <= dec_rs_d;
      dec_imm_q    <= dec_imm_d;
      dec_pc_q     <= dec_pc_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imm_index  = imem_instr[2:0];
  assign dec_valid  = dec_valid_q;
  assign dec_opcode = dec_opcode_q;
  assign dec_rd     = dec_rd_q;
  assign dec_rs     = dec_rs_q;
  assign dec_imm    = dec_imm_q;
  assign dec_pc     = dec_pc_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage with a behavioural instruction memory and immediate LUT.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants for each step of the program.
module tb_fetch_decode_stage;

  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_instr;
  logic [2:0]      imm_index;
  logic [7:0]      imm_data;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            dec_valid;
  logic [2:0]      dec_opcode;
  logic [2:0]      dec_rd;
  logic [2:0]      dec_rs;
  logic [7:0]      dec_imm;
  logic [PC_W-1:0] dec_pc;
  logic            halted;

  logic [8:0] mem [0:(1<<PC_W)-1];
  logic [7:0] lut [0:7];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];
  assign imm_data   = lut[imm_index];

  fetch_decode_stage #(.PC_W(PC_W), .HALT_INSTR(9'h1FF)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .imm_index     (imm_index),
    .imm_data      (imm_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .dec_valid     (dec_valid),
    .dec_opcode    (dec_opcode),
    .dec_rd        (dec_rd),
    .dec_rs        (dec_rs),
    .dec_imm       (dec_imm),
    .dec_pc        (dec_pc),
    .halted        (halted)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},  32'(dec_valid),  0);
    chk({tag, ".opcode"}, 32'(dec_opcode), 0);
    chk({tag, ".rd"},     32'(dec_rd),     0);
    chk({tag, ".rs"},     32'(dec_rs),     0);
    chk({tag, ".imm"},    32'(dec_imm),    0);
    chk({tag, ".pc"},     32'(dec_pc),     0);
    chk({tag, ".addr"},   32'(imem_addr),  0);
    chk({tag, ".halted"}, 32'(halted),     0);
  endtask

  logic [7:0] imm_exp [0:6];

  initial begin
    lut[0] = 8'd0;  lut[1] = 8'd1;  lut[2] = 8'd29; lut[3] = 8'd128;
    lut[4] = 8'd59; lut[5] = 8'd4;  lut[6] = 8'd2;  lut[7] = 8'd77;
    imm_exp[0] = 8'd0;  imm_exp[1] = 8'd1;  imm_exp[2] = 8'd29; imm_exp[3] = 8'd128;
    imm_exp[4] = 8'd59; imm_exp[5] = 8'd4;  imm_exp[6] = 8'd2;
    for (int a = 0; a < (1<<PC_W); a++) mem[a] = 9'h0C7;
    mem[0] = 9'h101;
    mem[1] = 9'h02A;
    mem[2] = 9'h1FF;

    reset = 1'b1; start = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;

    // Reset for two cycles, then everything must read zero (IDLE).
    step(); step();
    reset = 1'b0;
    chk_zero("reset");
    step();
    chk("idle.valid", 32'(dec_valid), 0);
    chk("idle.addr",  32'(imem_addr), 0);

    // Start: RUN with addr 0, first valid one cycle later.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start.addr",  32'(imem_addr), 0);
    chk("start.valid", 32'(dec_valid), 0);
    step();
    chk("i0.valid",  32'(dec_valid),  1);
    chk("i0.pc",     32'(dec_pc),     0);
    chk("i0.imm",    32'(dec_imm),    1);
    chk("i0.opcode", 32'(dec_opcode), 4);
    chk("i0.rs",     32'(dec_rs),     1);
    step();
    chk("i1.valid", 32'(dec_valid), 1);
    chk("i1.pc",    32'(dec_pc),    1);
    chk("i1.imm",   32'(dec_imm),   29);
    chk("i1.rd",    32'(dec_rd),    5);
    chk("i1.rs",    32'(dec_rs),    2);
    step();
    chk("halt.halted", 32'(halted),    1);
    chk("halt.valid",  32'(dec_valid), 0);
    chk("halt.addr",   32'(imem_addr), 2);

    // Branch in HALT is ignored.
    branch_taken = 1'b1; branch_target = 10'h100;
    step();
    branch_taken = 1'b0;
    chk("haltbr.addr",   32'(imem_addr), 2);
    chk("haltbr.halted", 32'(halted),    1);

    // New program for the immediate sweep: opcode 1, rd 2, rs = i.
    for (int a = 0; a < 7; a++) mem[a] = 9'h050 | 9'(a);

    // Restart from HALT.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart.halted", 32'(halted),    0);
    chk("restart.addr",   32'(imem_addr), 0);
    chk("restart.valid",  32'(dec_valid), 0);

    for (int i = 0; i < 7; i++) begin
      start = (i == 2);          // start while running must be ignored
      step();
      start = 1'b0;
      chk($sformatf("sweep%0d.valid", i),  32'(dec_valid),  1);
      chk($sformatf("sweep%0d.pc", i),     32'(dec_pc),     i);
      chk($sformatf("sweep%0d.imm", i),    32'(dec_imm),    imm_exp[i]);
      chk($sformatf("sweep%0d.opcode", i), 32'(dec_opcode), 1);
      chk($sformatf("sweep%0d.rd", i),     32'(dec_rd),     2);
      chk($sformatf("sweep%0d.rs", i),     32'(dec_rs),     i);
      if (i == 5) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          step();
          chk($sformatf("stall%0d.pc", s),    32'(dec_pc),    5);
          chk($sformatf("stall%0d.addr", s),  32'(imem_addr), 6);
          chk($sformatf("stall%0d.valid", s), 32'(dec_valid), 1);
        end
        stall = 1'b0;
      end
    end

    // Branch together with stall: branch wins, one bubble.
    branch_taken = 1'b1; branch_target = 10'h3F0; stall = 1'b1;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    chk("brst.addr",  32'(imem_addr), 10'h3F0);
    chk("brst.valid", 32'(dec_valid), 0);
    step();
    chk("brst.tgt.pc",    32'(dec_pc),    10'h3F0);
    chk("brst.tgt.valid", 32'(dec_valid), 1);
    chk("brst.tgt.imm",   32'(dec_imm),   77);

    // Wrap at the top of the address space.
    branch_taken = 1'b1; branch_target = 10'h3FF;
    step();
    branch_taken = 1'b0;
    chk("wrap.br.addr", 32'(imem_addr), 10'h3FF);
    step();
    chk("wrap.pc",    32'(dec_pc),    10'h3FF);
    chk("wrap.valid", 32'(dec_valid), 1);
    chk("wrap.addr",  32'(imem_addr), 0);
    step();
    chk("wrap.next.pc",  32'(dec_pc), 0);
    chk("wrap.next.imm", 32'(dec_imm), 0);

    // Reset in the middle of a stall.
    stall = 1'b1;
    step();
    chk("prereset.pc", 32'(dec_pc), 0);
    reset = 1'b1;
    step();
    reset = 1'b0; stall = 1'b0;
    chk_zero("midreset");
    step();
    chk("postreset.valid", 32'(dec_valid), 0);
    chk("postreset.addr",  32'(imem_addr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
